// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master (icache / dcache) to one-slave (L2) bus arbiter.
//                An owner is granted for a whole bus transaction. While a side
//                owns the bus, its request is forwarded to L2 combinationally.
//                The L2 ack is routed back to that owner in the same cycle.
//                After every completed transaction, one RELEASE cycle is
//                inserted. A 1-bit round-robin pointer resolves simultaneous
//                requests.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    i_cyc/i_stb/i_we         icache request qualifiers
//    i_adr/i_sel/i_dat_m      icache address, byte select, write data
//    i_ack/i_dat_s            icache completion, read data
//    d_*                      same set for the dcache side
//    l2_cyc/l2_stb/l2_we      request qualifiers towards L2
//    l2_adr/l2_sel/l2_dat_m   address, byte select, write data towards L2
//    l2_ack/l2_dat_s          L2 completion, read data
//    grant_i/grant_d          registered ownership status (one-hot or zero)
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  // icache side
  input  logic                i_cyc,
  input  logic                i_stb,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_adr,
  input  logic [DATA_W/8-1:0] i_sel,
  input  logic [DATA_W-1:0]   i_dat_m,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_dat_s,
  // dcache side
  input  logic                d_cyc,
  input  logic                d_stb,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_adr,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [DATA_W-1:0]   d_dat_m,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_dat_s,
  // L2 side
  output logic                l2_cyc,
  output logic                l2_stb,
  output logic                l2_we,
  output logic [ADDR_W-1:0]   l2_adr,
  output logic [DATA_W/8-1:0] l2_sel,
  output logic [DATA_W-1:0]   l2_dat_m,
  input  logic                l2_ack,
  input  logic [DATA_W-1:0]   l2_dat_s,
  // ownership status
  output logic                grant_i,
  output logic                grant_d
);

  // Pointer encoding: names the side that wins the next tie.
  localparam logic c_PTR_D = 1'b0;
  localparam logic c_PTR_I = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_I   = 2'd1,
    ST_OWN_D   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  logic   r_ptr;
  logic   r_grant_i;
  logic   r_grant_d;

  logic   w_pend_i;
  logic   w_pend_d;
  logic   w_own_i;
  logic   w_own_d;

  assign w_pend_i = i_cyc & i_stb;
  assign w_pend_d = d_cyc & d_stb;
  assign w_own_i  = (r_state == ST_OWN_I);
  assign w_own_d  = (r_state == ST_OWN_D);

  // --------------------------------------------------------------------------
  // Arbitration FSM. The grants are registered alongside the state, so each
  // grant is high exactly while its OWN_* state is current.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= c_PTR_D;
      r_grant_i <= 1'b0;
      r_grant_d <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pend_d && (!w_pend_i || r_ptr == c_PTR_D)) begin
            r_state   <= ST_OWN_D;
            r_grant_d <= 1'b1;
          end else if (w_pend_i) begin
            r_state   <= ST_OWN_I;
            r_grant_i <= 1'b1;
          end
        end
        ST_OWN_I: begin
          // A completion takes precedence over a simultaneous drop of cyc.
          if (l2_ack) begin
            r_state   <= ST_RELEASE;
            r_ptr     <= c_PTR_D;
            r_grant_i <= 1'b0;
          end else if (!i_cyc) begin
            // Abort: the pointer is left alone, so the tie-break is unchanged.
            r_state   <= ST_IDLE;
            r_grant_i <= 1'b0;
          end
        end
        ST_OWN_D: begin
          if (l2_ack) begin
            r_state   <= ST_RELEASE;
            r_ptr     <= c_PTR_I;
            r_grant_d <= 1'b0;
          end else if (!d_cyc) begin
            r_state   <= ST_IDLE;
            r_grant_d <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // One dead cycle lets the previous owner drop cyc/stb.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_grant_i <= 1'b0;
          r_grant_d <= 1'b0;
        end
      endcase
    end
  end

  assign grant_i = r_grant_i;
  assign grant_d = r_grant_d;

  // --------------------------------------------------------------------------
  // Request mux towards L2. Outside an OWN_* state, everything is forced to
  // zero.
  // --------------------------------------------------------------------------
  always_comb begin
    l2_cyc   = 1'b0;
    l2_stb   = 1'b0;
    l2_we    = 1'b0;
    l2_adr   = '0;
    l2_sel   = '0;
    l2_dat_m = '0;
    if (w_own_i) begin
      l2_cyc   = i_cyc;
      l2_stb   = i_stb;
      l2_we    = i_we;
      l2_adr   = i_adr;
      l2_sel   = i_sel;
      l2_dat_m = i_dat_m;
    end else if (w_own_d) begin
      l2_cyc   = d_cyc;
      l2_stb   = d_stb;
      l2_we    = d_we;
      l2_adr   = d_adr;
      l2_sel   = d_sel;
      l2_dat_m = d_dat_m;
    end
  end

  // The ack only reaches the current owner. Read data is shared by both sides.
  assign i_ack   = w_own_i & l2_ack;
  assign d_ack   = w_own_d & l2_ack;
  assign i_dat_s = l2_dat_s;
  assign d_dat_s = l2_dat_s;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, line-address width on all ports.
REQ-002 Parameter DATA_W, default 128, cache-line width on all data ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 i_cyc, i_stb, i_we  input  1 each  icache-side request qualifiers.
REQ-006 i_adr  input  ADDR_W; i_sel  input  DATA_W/8; i_dat_m  input  DATA_W  icache-side address, byte select, write data.
REQ-007 i_ack  output  1; i_dat_s  output  DATA_W  icache-side completion and read data.
REQ-008 d_cyc, d_stb, d_we  input  1 each; d_adr  input  ADDR_W; d_sel  input  DATA_W/8; d_dat_m  input  DATA_W  dcache-side request.
REQ-009 d_ack  output  1; d_dat_s  output  DATA_W  dcache-side completion and read data.
REQ-010 l2_cyc, l2_stb, l2_we  output  1 each; l2_adr  output  ADDR_W; l2_sel  output  DATA_W/8; l2_dat_m  output  DATA_W  request to L2.
REQ-011 l2_ack  input  1; l2_dat_s  input  DATA_W  L2 completion and read data.
REQ-012 grant_i, grant_d  output  1 each  registered ownership status, one-hot or both zero.

Function
REQ-013 States: IDLE, OWN_I, OWN_D, RELEASE; state and grant_* registered.
REQ-014 Request pending for a side = its cyc AND stb both high.
REQ-015 IDLE: no pending -> stay IDLE; only one pending -> that side's OWN_* next cycle; both pending -> side indicated by priority pointer.
REQ-016 Priority pointer 1 bit, reset to dcache; on every completed transaction it points to the side not just served.
REQ-017 Request in IDLE at cycle n -> l2_stb/l2_cyc high from cycle n+1; minimum added latency exactly one cycle.
REQ-018 OWN_x: l2_cyc, l2_stb, l2_we, l2_adr, l2_sel, l2_dat_m driven combinationally from owner's inputs; non-owner inputs ignored.
REQ-019 OWN_x: l2_ack routed combinationally to x_ack same cycle; non-owner ack held 0 at all times.
REQ-020 l2_dat_s broadcast unconditionally to i_dat_s and d_dat_s.
REQ-021 OWN_x with l2_ack high -> RELEASE next cycle; pointer updated same edge.
REQ-022 RELEASE: all l2_* qualifiers low, both grants low, lasts exactly one cycle, then IDLE; gives owner one cycle to drop cyc/stb.
REQ-023 OWN_x with owner cyc low and l2_ack low (abort) -> IDLE next cycle; pointer NOT updated; l2_cyc/l2_stb follow owner inputs, so low that cycle.
REQ-024 Ownership never changes while owner cyc high and l2_ack not yet seen; no preemption.
REQ-025 Starvation bound: with both sides continuously pending, grants strictly alternate.
REQ-026 Outside OWN_*: l2_cyc, l2_stb, l2_we low, l2_adr and l2_sel zero, l2_dat_m zero.
REQ-027 l2_ack arriving in IDLE or RELEASE ignored: no x_ack, no state change.

Reset
REQ-028 rst high at any edge, including mid-transaction: state IDLE, pointer dcache, grant_i = grant_d = 0, all l2_* qualifiers 0, i_ack = d_ack = 0 from following cycle.
REQ-029 In-flight L2 transaction is dropped on reset; no completion reported to either side.

Verification
REQ-030 Icache-only read: i_cyc=i_stb=1, i_adr=0x0A4 at cycle 0 -> l2_stb=1, l2_adr=0x0A4 at cycle 1; l2_ack at cycle 4 -> i_ack=1 at cycle 4, RELEASE cycle 5, IDLE cycle 6.
REQ-031 Simultaneous requests after reset, i_adr=0x100, d_adr=0x200 -> dcache served first (l2_adr=0x200), icache next (l2_adr=0x100) after one RELEASE cycle.
REQ-032 Both held pending across 4 transactions -> grant order D, I, D, I; d_ack never asserted during icache ownership and vice versa.
REQ-033 Dcache write, d_we=1, d_dat_m=128'hDEAD_BEEF, d_sel=16'hFFFF -> l2_we=1, l2_dat_m and l2_sel match exactly while grant_d=1.
REQ-034 Owner drops cyc before ack -> IDLE next cycle, pointer unchanged; later simultaneous request -> same side as before abort wins.
REQ-035 rst asserted in OWN_I with ack pending -> next cycle all outputs zero, state IDLE; late l2_ack yields no i_ack.
